// File: rtl/conv_featuremap_acc_if.sv
// Pixel stream bundle for the channel-summing feature-map accumulator:
// frame clear and pixel input from the producer, activated pixel plus its
// coordinates back to the consumer.
`timescale 1ns/1ps

interface conv_featuremap_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 3,
  parameter int CW         = 9
);
  logic                         clr;
  logic [CH_NUM*DATA_WIDTH-1:0] data_in;
  logic                         valid_in;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid_out;
  logic [CW-1:0]                col_out;
  logic [CW-1:0]                row_out;
  logic                         last_out;

  // Producer/consumer side.
  modport master (
    output clr, data_in, valid_in,
    input  data_out, valid_out, col_out, row_out, last_out
  );

  // Accumulator side.
  modport slave (
    input  clr, data_in, valid_in,
    output data_out, valid_out, col_out, row_out, last_out
  );
endinterface

// File: rtl/conv_featuremap_acc.sv
// Sums CH_NUM signed fixed-point channels per pixel through a registered
// adder tree, adds a bias, applies optional leaky ReLU, saturates to
// DATA_WIDTH and tags each result with its (col,row) in the feature map.
// Latency is clog2(CH_NUM)+2 cycles; no backpressure.
`timescale 1ns/1ps

module conv_featuremap_acc #(
  parameter int                            DATA_WIDTH = 16,
  parameter int                            FRAC_BITS  = 8,
  parameter int                            CH_NUM     = 3,
  parameter int                            IMG_SIZE   = 416,
  parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
  parameter bit                            LEAKY_EN   = 1'b1,
  parameter int                            LEAK_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_featuremap_acc_if.slave  bus
);

  // Tree depth, padded leaf count and a sum width that cannot overflow.
  localparam int L    = $clog2(CH_NUM);
  localparam int N    = 1 << L;
  localparam int SW   = DATA_WIDTH + L + 1;
  localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int ROOT = 2 * N - 2;

  typedef logic signed [SW-1:0] acc_t;

  localparam acc_t          SAT_MAX  = acc_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam acc_t          SAT_MIN  = ~SAT_MAX;
  localparam acc_t          BIAS_EXT = acc_t'(BIAS);
  localparam logic [CW-1:0] EDGE_MAX = CW'(IMG_SIZE - 1);

  // Reject parameter sets the datapath is not built for.
  if (CH_NUM < 1 || CH_NUM > 64 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH ||
      IMG_SIZE < 1 || LEAK_SHIFT < 0) begin : g_param_check
    $error("conv_featuremap_acc: unsupported parameter set");
  end

  // Tree nodes are stored level after level: leaves at 0..N-1, then N/2
  // nodes of level 1, and so on up to the root at index 2N-2.
  function automatic int node_off(input int lvl);
    return 2 * N - ((2 * N) >> lvl);
  endfunction

  logic [N*DATA_WIDTH-1:0] w_din_pad;
  acc_t                    r_node [0:2*N-2];
  logic [L:0]              r_vld;
  acc_t                    w_biased;
  acc_t                    w_act;
  logic [DATA_WIDTH-1:0]   w_sat;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic                    r_valid_out;
  logic [CW-1:0]           r_col;
  logic [CW-1:0]           r_row;

  // Missing channels of a non-power-of-two count become zero leaves.
  assign w_din_pad = (N*DATA_WIDTH)'(bus.data_in);

  // Input register stage and registered adder-tree levels.
  // NOTE: the data path has no reset; stale contents are harmless because
  // every result is qualified by its own valid bit, and dropping the reset
  // keeps the wide tree registers out of the reset network.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      r_node[k] <= acc_t'($signed(w_din_pad[k*DATA_WIDTH +: DATA_WIDTH]));
    end
    for (int lvl = 1; lvl <= L; lvl++) begin
      for (int j = 0; j < (N >> lvl); j++) begin
        // NOTE: non-blocking assignment makes each level read the previous
        // level's old value, giving one register stage per tree level.
        r_node[node_off(lvl) + j] <= r_node[node_off(lvl-1) + 2*j]
                                   + r_node[node_off(lvl-1) + 2*j + 1];
      end
    end
  end

  // Bias, leaky ReLU (floor via arithmetic shift) and saturation.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    w_biased = r_node[ROOT] + BIAS_EXT;
    w_act    = w_biased;
    w_sat    = w_biased[DATA_WIDTH-1:0];
    if (LEAKY_EN && w_biased[SW-1]) begin
      w_act = w_biased >>> LEAK_SHIFT;
    end
    if (w_act > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_act < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_act[DATA_WIDTH-1:0];
    end
  end

  // Valid pipeline and output register; clr flushes everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else if (bus.clr) begin
      r_vld       <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_vld[0] <= bus.valid_in;
      for (int i = 1; i <= L; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_valid_out <= r_vld[L];
      if (r_vld[L]) begin
        r_data_out <= w_sat;
      end
    end
  end

  // Coordinates of the pixel on data_out; step after each output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_valid_out) begin
      if (r_col == EDGE_MAX) begin
        r_col <= '0;
        r_row <= (r_row == EDGE_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.col_out   = r_col;
  assign bus.row_out   = r_row;
  assign bus.last_out  = r_valid_out && (r_col == EDGE_MAX) && (r_row == EDGE_MAX);

endmodule

// File: tb/tb_conv_featuremap_acc.sv
// Directed bench: three accumulators (leaky, plain, biased) share one
// 3-channel stimulus stream on a 4x4 map; expected values are worked out by hand.
`timescale 1ns/1ps

module tb_conv_featuremap_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_clr;
  logic        tb_valid;
  logic [47:0] tb_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  conv_featuremap_acc_if #(.DATA_WIDTH(16), .CH_NUM(3), .CW(2)) if_l ();
  conv_featuremap_acc_if #(.DATA_WIDTH(16), .CH_NUM(3), .CW(2)) if_n ();
  conv_featuremap_acc_if #(.DATA_WIDTH(16), .CH_NUM(3), .CW(2)) if_b ();

  assign if_l.clr = tb_clr;  assign if_l.valid_in = tb_valid;  assign if_l.data_in = tb_data;
  assign if_n.clr = tb_clr;  assign if_n.valid_in = tb_valid;  assign if_n.data_in = tb_data;
  assign if_b.clr = tb_clr;  assign if_b.valid_in = tb_valid;  assign if_b.data_in = tb_data;

  conv_featuremap_acc #(.CH_NUM(3), .IMG_SIZE(4), .LEAKY_EN(1'b1)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l));
  conv_featuremap_acc #(.CH_NUM(3), .IMG_SIZE(4), .LEAKY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n));
  conv_featuremap_acc #(.CH_NUM(3), .IMG_SIZE(4), .LEAKY_EN(1'b1), .BIAS(16'sh0080)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive(input logic v, input logic c,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    tb_valid = v;
    tb_clr   = c;
    tb_data  = {a2, a1, a0};
  endtask

  // One pixel, then idle; valid_out must rise on the 4th edge only.
  task automatic pulse_and_check(input string tag,
                                 input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                 input logic [15:0] exp_l, input logic [15:0] exp_n,
                                 input logic [15:0] exp_b);
    @(negedge clk);
    drive(1'b1, 1'b0, a0, a1, a2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'hAAAA, 16'h5555, 16'hAAAA);
      check({tag, " valid@", $sformatf("%0d", c)}, if_l.valid_out, c == 4);
      if (c == 4) begin
        check({tag, " leaky"}, if_l.data_out, exp_l);
        check({tag, " plain"}, if_n.data_out, exp_n);
        check({tag, " bias"},  if_b.data_out, exp_b);
      end
    end
  endtask

  // One pixel on channel 0 whose beat must appear after 4 edges at (col,row).
  task automatic send_pos(input string tag, input logic [15:0] a0,
                          input logic [1:0] exp_col, input logic [1:0] exp_row);
    @(negedge clk);
    drive(1'b1, 1'b0, a0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h1234, 16'h1234, 16'h1234);
      check({tag, " valid@", $sformatf("%0d", c)}, if_l.valid_out, c == 4);
      if (c == 4) begin
        check({tag, " data"}, if_l.data_out, a0);
        check({tag, " col"},  if_l.col_out,  exp_col);
        check({tag, " row"},  if_l.row_out,  exp_row);
      end
    end
  endtask

  // Count output beats over a window where none may appear.
  task automatic expect_quiet(input string tag, input int cycles);
    int beats;
    beats = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (if_l.valid_out || if_n.valid_out || if_b.valid_out) beats++;
    end
    check({tag, " beats"}, beats, 0);
  endtask

  initial begin
    int gaps [16] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 2, 0, 0, 1, 0, 3, 0};
    int sent, gap_left, beats;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check("reset valid_out", if_l.valid_out, 0);
    check("reset data_out",  if_l.data_out,  0);
    check("reset last_out",  if_l.last_out,  0);
    check("reset col",       if_l.col_out,   0);
    check("reset row",       if_l.row_out,   0);
    rst = 1'b0;

    // Sum, leak, bias and saturation vectors (Q8.8).
    pulse_and_check("unit",     16'h0100, 16'h0100, 16'h0100, 16'h0300, 16'h0300, 16'h0380);
    pulse_and_check("neg",      16'hFE00, 16'hFE00, 16'hFE00, 16'hFF40, 16'hFA00, 16'hFF50);
    pulse_and_check("pos_sat",  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    pulse_and_check("neg_sat",  16'h8000, 16'h8000, 16'h8000, 16'hD000, 16'h8000, 16'hD010);
    pulse_and_check("zero",     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080);
    pulse_and_check("mixed",    16'h0100, 16'hFF00, 16'h0080, 16'h0080, 16'h0080, 16'h0100);
    pulse_and_check("floor1",   16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h007F);
    pulse_and_check("floor9",   16'hFFF7, 16'h0000, 16'h0000, 16'hFFFE, 16'hFFF7, 16'h0077);

    // Four back-to-back pixels; reset lands with the first on data_out.
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'(16'h0100 * (p + 1)), 16'h0000, 16'h0000);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("pre-rst valid_out", if_l.valid_out, 1);
    check("pre-rst data_out",  if_l.data_out,  16'h0100);
    #1 rst = 1'b1;
    #1;
    check("async rst valid_out", if_l.valid_out, 0);
    check("async rst data_out",  if_l.data_out,  0);
    check("async rst col",       if_l.col_out,   0);
    check("async rst row",       if_l.row_out,   0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("rst flush", 8);
    send_pos("after rst", 16'h0040, 2'd0, 2'd0);

    // A pixel in flight plus one coincident with clr are both dropped.
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0500, 16'h0000, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    expect_quiet("clr flush", 6);
    send_pos("after clr", 16'h0300, 2'd0, 2'd0);

    // Full 4x4 frame with gaps in valid_in.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    sent = 0;
    gap_left = 0;
    beats = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (if_l.valid_out) begin
        check($sformatf("frame col #%0d", beats),  if_l.col_out,  beats % 4);
        check($sformatf("frame row #%0d", beats),  if_l.row_out,  beats / 4);
        check($sformatf("frame last #%0d", beats), if_l.last_out, beats == 15);
        check($sformatf("frame data #%0d", beats), if_l.data_out, beats * 256);
        beats++;
      end else begin
        check($sformatf("idle last @%0d", cyc), if_l.last_out, 0);
      end
      if (sent < 16 && gap_left == 0) begin
        drive(1'b1, 1'b0, 16'(sent * 256), 16'h0000, 16'h0000);
        gap_left = gaps[sent];
        sent++;
      end else begin
        drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        if (gap_left > 0) gap_left--;
      end
    end
    check("frame beats", beats, 16);
    check("frame end col", if_l.col_out, 0);
    check("frame end row", if_l.row_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_featuremap_acc.md
CONV_FEATUREMAP_ACC -- requirements
Module: conv_featuremap_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each signed fixed-point channel sample and of the result.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of the two's-complement Q format.
REQ-003 Parameter CH_NUM, default 3, range 1-64: number of input channels summed per pixel.
REQ-004 Parameter IMG_SIZE, default 416: square feature-map edge length in pixels.
REQ-005 Parameter BIAS, default 0: signed DATA_WIDTH bias in the same Q format.
REQ-006 Parameter LEAKY_EN, default 1: 1 enables leaky ReLU; 0 passes values unchanged.
REQ-007 Parameter LEAK_SHIFT, default 3: arithmetic right-shift used as the negative slope.
REQ-008 Clk  input  1: single clock; all state updates on the rising edge.
REQ-009 Rst  input  1: asynchronous, active-high reset.
REQ-010 clr  input  1: synchronous frame clear.
REQ-011 data_in  input  CH_NUM*DATA_WIDTH: channel k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-012 valid_in  input  1: data_in carries one pixel this cycle.
REQ-013 data_out  output  DATA_WIDTH: activated, saturated pixel result.
REQ-014 valid_out  output  1: data_out is valid this cycle.
REQ-015 col_out, row_out  output  clog2(IMG_SIZE) each: coordinates of the current output pixel.
REQ-016 last_out  output  1: asserted with the final pixel of a frame.

Function
REQ-017 The pipeline SHALL be: 1 input register stage, L = clog2(CH_NUM) registered adder-tree stages (L=0 when CH_NUM=1), and 1 bias/activation/saturation stage; latency SHALL be L+2 cycles (4 for CH_NUM=3).
REQ-018 Each channel SHALL be sign-extended to DATA_WIDTH+clog2(CH_NUM)+1 bits before summation; odd tree levels SHALL pad with zero; no intermediate overflow is permitted.
REQ-019 The final stage SHALL compute s = sum + BIAS; if LEAKY_EN=1 and s<0, then s = s >>> LEAK_SHIFT (floor rounding).
REQ-020 After activation, s SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 There is no backpressure; the pipeline advances every cycle and valid bubbles propagate with their data slots.
REQ-022 valid_in may deassert on any cycle; data_in SHALL be ignored when valid_in=0.
REQ-023 valid_out SHALL be valid_in delayed by exactly L+2 cycles.
REQ-024 col_out/row_out SHALL hold the coordinates of the pixel on data_out while valid_out=1, then advance after each valid_out beat: col increments, wraps at IMG_SIZE-1 to 0 and increments row.
REQ-025 last_out SHALL equal valid_out AND col=IMG_SIZE-1 AND row=IMG_SIZE-1; after that beat both counters SHALL return to 0.
REQ-026 clr=1 SHALL zero all pipeline valid bits and both counters on the next edge; valid_in in the same cycle SHALL be dropped (clr wins).
REQ-027 Data registers may hold stale values when their valid bit is 0; outputs SHALL be qualified only by valid_out.

Reset
REQ-028 Asserting Rst SHALL immediately clear all valid bits, counters, data_out (to 0), valid_out and last_out, regardless of Clk.
REQ-029 Pixels in flight when Rst is asserted SHALL be discarded; the first valid_in after deassertion SHALL be output at (0,0).

Verification
REQ-030 The bench SHALL cover these directed scenarios, with CH_NUM=3, DATA_WIDTH=16, FRAC_BITS=8 and BIAS=0 unless stated:
- Channels 0x0100, 0x0100, 0x0100 with valid_in=1 -> data_out 0x0300 with valid_out=1 exactly 4 cycles later.
- Channels 0xFE00 x3, LEAKY_EN=1 -> sum -6.0, data_out 0xFF40 (-0.75); with LEAKY_EN=0 -> 0xFA00.
- Channels 0x7FFF x3 -> data_out 0x7FFF; channels 0x8000 x3 -> 0xD000 with leaky enabled, and 0x8000 (saturated) with LEAKY_EN=0.
- IMG_SIZE=4, 16 valid pixels with random gaps -> col/row sequence (0,0)..(3,3), last_out only on the 16th beat, then counters back at (0,0).
- BIAS=0x0080, channels 0x0000 x3 -> data_out 0x0080.
- Rst pulse while 3 pixels are in flight -> no valid_out for them; the next input emerges at (0,0) after 4 cycles; a clr coincident with valid_in -> that pixel is dropped.
